// File: rtl/i2s_mic_streamer.sv
// i2s_mic_streamer
//   Captures one channel of a codec ADC I2S stream and queues the samples in a
//   small FIFO. The samples are presented on a registered valid/ready stream.
//   The I2S inputs are asynchronous; every register runs on clk.
//   Optional build macro QUIET_GEN_EN enables the quiet_period calibration
//   window. The window stays open until CAL_SAMPLES samples have been popped,
//   and cal_request restarts it. Without the macro, quiet_period is tied low.
module i2s_mic_streamer #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned CHANNEL     = 0,
    parameter int unsigned CAL_SAMPLES = 4096
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i2s_bclk,
    input  logic                          i2s_lrclk,
    input  logic                          i2s_adcdat,
    output logic [DATA_WIDTH-1:0]         audio_output,
    output logic                          audio_output_valid,
    input  logic                          audio_output_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic                          overflow,
    output logic                          quiet_period,
    input  logic                          cal_request
);

    localparam int unsigned PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned FILL_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned BITC_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic        CHAN_BIT = (CHANNEL != 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SKIP  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_PUSH  = 2'd3
    } rx_state_t;

    // ------------------------------------------------------------------
    // Synchronisers and bit-clock edge detection
    // ------------------------------------------------------------------
    logic bclk_meta_r, bclk_sync_r, bclk_prev_r;
    logic lr_meta_r, lr_sync_r;
    logic dat_meta_r, dat_sync_r;
    logic lr_prev_r, lr_prev_vld_r;
    logic bclk_rise_s;
    logic lr_change_s;

    // Two-flop synchronisers for the three codec lines, plus bclk history
    always_ff @(posedge clk) begin
        if (reset) begin
            bclk_meta_r <= 1'b0;
            bclk_sync_r <= 1'b0;
            bclk_prev_r <= 1'b0;
            lr_meta_r   <= 1'b0;
            lr_sync_r   <= 1'b0;
            dat_meta_r  <= 1'b0;
            dat_sync_r  <= 1'b0;
        end else begin
            bclk_meta_r <= i2s_bclk;
            bclk_sync_r <= bclk_meta_r;
            bclk_prev_r <= bclk_sync_r;
            lr_meta_r   <= i2s_lrclk;
            lr_sync_r   <= lr_meta_r;
            dat_meta_r  <= i2s_adcdat;
            dat_sync_r  <= dat_meta_r;
        end
    end

    assign bclk_rise_s = bclk_sync_r & ~bclk_prev_r;

    // Word-select history, captured on each bit-clock rise.
    // lr_prev_vld_r blocks a false frame start from the cleared history
    // right after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            lr_prev_r     <= 1'b0;
            lr_prev_vld_r <= 1'b0;
        end else if (bclk_rise_s) begin
            lr_prev_r     <= lr_sync_r;
            lr_prev_vld_r <= 1'b1;
        end else begin
            lr_prev_r     <= lr_prev_r;
            lr_prev_vld_r <= lr_prev_vld_r;
        end
    end

    assign lr_change_s = bclk_rise_s & lr_prev_vld_r & (lr_sync_r != lr_prev_r);

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    rx_state_t             state_r, state_nxt_s;
    logic                  load_cnt_s;
    logic                  shift_en_s;
    logic                  push_s;
    logic [BITC_W-1:0]     bit_cnt_r;
    logic [DATA_WIDTH-1:0] shreg_r;

    // Receive state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and datapath strobes. The rise that exposes a word-select
    // change is the I2S delay slot. SKIP only arms the bit counter during the
    // following clk, so the next rise carries the MSB.
    always_comb begin
        state_nxt_s = state_r;
        load_cnt_s  = 1'b0;
        shift_en_s  = 1'b0;
        push_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (lr_change_s && (lr_sync_r == CHAN_BIT)) begin
                    state_nxt_s = ST_SKIP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SKIP: begin
                load_cnt_s  = 1'b1;
                state_nxt_s = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (lr_change_s) begin
                    // truncated word: drop it and resynchronise to the new slot
                    if (lr_sync_r == CHAN_BIT) begin
                        state_nxt_s = ST_SKIP;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else if (bclk_rise_s) begin
                    shift_en_s = 1'b1;
                    if (bit_cnt_r == {BITC_W{1'b0}}) begin
                        state_nxt_s = ST_PUSH;
                    end else begin
                        state_nxt_s = ST_SHIFT;
                    end
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_PUSH: begin
                push_s      = 1'b1;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // MSB-first shift register and bit counter
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt_r <= {BITC_W{1'b0}};
            shreg_r   <= {DATA_WIDTH{1'b0}};
        end else if (load_cnt_s) begin
            bit_cnt_r <= BITC_W'(DATA_WIDTH - 1);
            shreg_r   <= shreg_r;
        end else if (shift_en_s) begin
            shreg_r[bit_cnt_r] <= dat_sync_r;
            bit_cnt_r          <= bit_cnt_r - BITC_W'(1);
        end else begin
            bit_cnt_r <= bit_cnt_r;
            shreg_r   <= shreg_r;
        end
    end

    // ------------------------------------------------------------------
    // Sample FIFO with registered head
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r, rd_ptr_r;
    logic [PTR_W-1:0]      wr_ptr_nxt_s, rd_ptr_nxt_s;
    logic [FILL_W-1:0]     count_r, count_nxt_s;
    logic [DATA_WIDTH-1:0] head_nxt_s;
    logic                  full_s, pop_s, push_ok_s, drop_s;
    logic                  valid_r, overflow_r;
    logic [DATA_WIDTH-1:0] out_r;

    assign full_s    = (count_r == FILL_W'(FIFO_DEPTH));
    assign pop_s     = valid_r & audio_output_ready;
    // when full, a simultaneous pop makes room for the incoming sample
    assign push_ok_s = push_s & (~full_s | pop_s);
    assign drop_s    = push_s & full_s & ~pop_s;

    // Next pointers, occupancy and next head value. A sample written this
    // cycle into the slot about to become the head is forwarded directly.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        head_nxt_s   = {DATA_WIDTH{1'b0}};
        if (push_ok_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        case ({push_ok_s, pop_s})
            2'b10:   count_nxt_s = count_r + FILL_W'(1);
            2'b01:   count_nxt_s = count_r - FILL_W'(1);
            default: count_nxt_s = count_r;
        endcase
        if (push_ok_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_nxt_s = shreg_r;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= shreg_r;
        end
    end

    // Pointers, occupancy, registered stream outputs and sticky overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {FILL_W{1'b0}};
            valid_r    <= 1'b0;
            out_r      <= {DATA_WIDTH{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            valid_r  <= (count_nxt_s != {FILL_W{1'b0}});
            if (count_nxt_s != {FILL_W{1'b0}}) begin
                out_r <= head_nxt_s;
            end else begin
                out_r <= out_r;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    assign audio_output       = out_r;
    assign audio_output_valid = valid_r;
    assign fill_level         = count_r;
    assign overflow           = overflow_r;

    // ------------------------------------------------------------------
    // Quiet-period calibration window
    // ------------------------------------------------------------------
`ifdef QUIET_GEN_EN
    localparam int unsigned CAL_W = $clog2(CAL_SAMPLES + 1);

    logic [CAL_W-1:0] cal_cnt_r, cal_cnt_nxt_s;
    logic             quiet_r;

    // Saturating pop counter; a restart request wins over a coincident pop
    always_comb begin
        cal_cnt_nxt_s = cal_cnt_r;
        if (cal_request) begin
            cal_cnt_nxt_s = {CAL_W{1'b0}};
        end else if (pop_s && (cal_cnt_r < CAL_W'(CAL_SAMPLES))) begin
            cal_cnt_nxt_s = cal_cnt_r + CAL_W'(1);
        end else begin
            cal_cnt_nxt_s = cal_cnt_r;
        end
    end

    // Window counter and registered window flag
    always_ff @(posedge clk) begin
        if (reset) begin
            cal_cnt_r <= {CAL_W{1'b0}};
            quiet_r   <= 1'b1;
        end else begin
            cal_cnt_r <= cal_cnt_nxt_s;
            quiet_r   <= (cal_cnt_nxt_s < CAL_W'(CAL_SAMPLES));
        end
    end

    assign quiet_period = quiet_r;
`else
    logic cal_request_unused_s;

    assign cal_request_unused_s = cal_request;
    assign quiet_period         = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_mic_streamer.sv
// tb_i2s_mic_streamer
//   Directed bench for i2s_mic_streamer. bclk runs at clk/8. Each half frame
//   has 18 bits: the delay slot, 16 data bits MSB first, then one pad bit.
//   Inputs change on the clk falling edge. Pops are recorded 1 ns before each
//   rising edge. Expectations for quiet_period follow QUIET_GEN_EN.
module tb_i2s_mic_streamer;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int CAL   = 8;
`ifdef QUIET_GEN_EN
    localparam logic Q_EN = 1'b1;
`else
    localparam logic Q_EN = 1'b0;
`endif

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      bclk, lrclk, adcdat;
    logic [DW-1:0]             audio_output;
    logic                      audio_output_valid;
    logic                      audio_output_ready;
    logic [$clog2(DEPTH):0]    fill_level;
    logic                      overflow;
    logic                      quiet_period;
    logic                      cal_request;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] pop_q [$];

    i2s_mic_streamer #(
        .DATA_WIDTH  (DW),
        .FIFO_DEPTH  (DEPTH),
        .CHANNEL     (0),
        .CAL_SAMPLES (CAL)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .i2s_bclk           (bclk),
        .i2s_lrclk          (lrclk),
        .i2s_adcdat         (adcdat),
        .audio_output       (audio_output),
        .audio_output_valid (audio_output_valid),
        .audio_output_ready (audio_output_ready),
        .fill_level         (fill_level),
        .overflow           (overflow),
        .quiet_period       (quiet_period),
        .cal_request        (cal_request)
    );

    always #5 clk = ~clk;

    // record each accepted sample just before the edge that consumes it
    always begin
        @(negedge clk);
        #4;
        if (audio_output_valid && audio_output_ready) pop_q.push_back(audio_output);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one bit cell: falling half drives data, rising half optionally raises ready
    task automatic send_bit(input logic lr, input logic d, input int ready_at);
        bclk   = 1'b0;
        lrclk  = lr;
        adcdat = d;
        repeat (4) @(negedge clk);
        bclk = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == ready_at) audio_output_ready = 1'b1;
        end
    endtask

    // delay slot plus 16 data bits; returns 4 clk after the LSB rise
    task automatic send_word(input logic lr, input logic [DW-1:0] w, input int ready_at);
        send_bit(lr, 1'b0, -1);
        for (int i = DW - 1; i >= 0; i--) send_bit(lr, w[i], (i == 0) ? ready_at : -1);
    endtask

    task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
        send_word(1'b0, l, -1);
        send_bit(1'b0, 1'b0, -1);
        send_word(1'b1, r, -1);
        send_bit(1'b1, 1'b0, -1);
    endtask

    initial begin
        logic [DW-1:0] w2;
        reset              = 1'b1;
        bclk               = 1'b0;
        lrclk              = 1'b1;
        adcdat             = 1'b0;
        audio_output_ready = 1'b1;
        cal_request        = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(audio_output_valid), 32'd0);
        check("rst_fill", 32'(fill_level), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_data", 32'(audio_output), 32'd0);
        check("rst_quiet", 32'(quiet_period), 32'(Q_EN));
        reset = 1'b0;
        send_bit(1'b1, 1'b0, -1);
        send_bit(1'b1, 1'b0, -1);

        // left 8001, right 1234: only the left word appears, T+2 after the LSB rise
        w2 = 16'h8001;
        send_bit(1'b0, 1'b0, -1);
        for (int i = DW - 1; i >= 1; i--) send_bit(1'b0, w2[i], -1);
        bclk = 1'b0; adcdat = w2[0];
        repeat (4) @(negedge clk);
        bclk = 1'b1;
        repeat (3) @(negedge clk);
        check("lat_valid_early", 32'(audio_output_valid), 32'd0);
        @(negedge clk);
        check("lat_valid", 32'(audio_output_valid), 32'd1);
        check("lat_data", 32'(audio_output), 32'h8001);
        check("lat_fill", 32'(fill_level), 32'd1);
        @(negedge clk);
        check("lat_popped", 32'(audio_output_valid), 32'd0);
        send_bit(1'b0, 1'b0, -1);
        send_word(1'b1, 16'h1234, -1);
        send_bit(1'b1, 1'b0, -1);
        check("one_pop_cnt", 32'(pop_q.size()), 32'd1);
        check("one_pop_val", 32'(pop_q[0]), 32'h8001);

        // overflow: five words into a four-deep FIFO with ready low
        pop_q.delete();
        audio_output_ready = 1'b0;
        for (int w = 1; w <= 4; w++) send_frame(16'(w), 16'hAAAA);
        check("full_fill", 32'(fill_level), 32'd4);
        check("full_no_ovf", 32'(overflow), 32'd0);
        send_frame(16'd5, 16'hAAAA);
        check("ovf_fill", 32'(fill_level), 32'd4);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_hold", 32'(audio_output), 32'd1);
        audio_output_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("drain_data", 32'(audio_output), 32'(i));
            check("drain_valid", 32'(audio_output_valid), 32'd1);
            @(negedge clk);
        end
        check("drain_empty", 32'(audio_output_valid), 32'd0);
        check("drain_fill", 32'(fill_level), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // reset in the middle of a left word with one sample queued
        audio_output_ready = 1'b0;
        send_frame(16'h0011, 16'h0000);
        check("pre_rst_fill", 32'(fill_level), 32'd1);
        w2 = 16'h5A5A;
        send_bit(1'b0, 1'b0, -1);
        for (int i = DW - 1; i >= 8; i--) send_bit(1'b0, w2[i], -1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_valid", 32'(audio_output_valid), 32'd0);
        check("mid_rst_fill", 32'(fill_level), 32'd0);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        check("mid_rst_data", 32'(audio_output), 32'd0);
        check("mid_rst_quiet", 32'(quiet_period), 32'(Q_EN));
        for (int i = 7; i >= 0; i--) send_bit(1'b0, w2[i], -1);
        send_bit(1'b0, 1'b0, -1);
        send_word(1'b1, 16'h0000, -1);
        send_bit(1'b1, 1'b0, -1);
        check("post_rst_nopush", 32'(fill_level), 32'd0);

        // full FIFO, ready rises in the push cycle: push and pop together
        for (int w = 1; w <= 4; w++) send_frame(16'(w), 16'h0000);
        check("pp_full", 32'(fill_level), 32'd4);
        pop_q.delete();
        send_word(1'b0, 16'd5, 2);
        check("pp_fill", 32'(fill_level), 32'd4);
        check("pp_ovf", 32'(overflow), 32'd0);
        check("pp_head", 32'(audio_output), 32'd2);
        send_bit(1'b0, 1'b0, -1);
        check("pp_cnt", 32'(pop_q.size()), 32'd5);
        for (int i = 0; i < 5; i++) check("pp_order", 32'(pop_q[i]), 32'(i + 1));
        check("pp_ovf_end", 32'(overflow), 32'd0);
        send_word(1'b1, 16'h0000, -1);
        send_bit(1'b1, 1'b0, -1);

        // lrclk toggles after 10 bits: partial word dropped, next word intact
        pop_q.delete();
        send_bit(1'b0, 1'b0, -1);
        for (int i = 0; i < 10; i++) send_bit(1'b0, 1'b1, -1);
        send_word(1'b1, 16'h0F0F, -1);
        send_bit(1'b1, 1'b0, -1);
        check("trunc_nopush", 32'(pop_q.size()), 32'd0);
        send_frame(16'hBEEF, 16'h0000);
        check("trunc_cnt", 32'(pop_q.size()), 32'd1);
        check("trunc_val", 32'(pop_q[0]), 32'hBEEF);

        // calibration window over CAL pops, then a restart request
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int w = 1; w < CAL; w++) send_frame(16'(w), 16'h0000);
        check("cal_before", 32'(quiet_period), 32'(Q_EN));
        send_word(1'b0, 16'(CAL), -1);
        check("cal_pop8_cycle", 32'(quiet_period), 32'(Q_EN));
        @(negedge clk);
        check("cal_fall", 32'(quiet_period), 32'd0);
        send_bit(1'b0, 1'b0, -1);
        send_word(1'b1, 16'h0000, -1);
        send_bit(1'b1, 1'b0, -1);
        check("cal_low_holds", 32'(quiet_period), 32'd0);
        cal_request = 1'b1;
        @(negedge clk);
        cal_request = 1'b0;
        check("cal_rearm", 32'(quiet_period), 32'(Q_EN));
        for (int w = 1; w < CAL; w++) send_frame(16'(w), 16'h0000);
        check("cal2_before", 32'(quiet_period), 32'(Q_EN));
        send_word(1'b0, 16'(CAL), -1);
        check("cal2_pop8_cycle", 32'(quiet_period), 32'(Q_EN));
        @(negedge clk);
        check("cal2_fall", 32'(quiet_period), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
